// File: rtl/frame_flash_filter_if.sv
// Pixel-side bundle of the frame flash filter: object-mux pixel in, timing and
// game-state levels in, filtered pixel and flash indicator out.
interface frame_flash_filter_if;
  logic [7:0] RGBIn;
  logic       displayActive;
  logic       startOfFrame;
  logic       win;
  logic       lose;
  logic [7:0] RGBOut;
  logic       flashActive;

  modport master (
    output RGBIn, displayActive, startOfFrame, win, lose,
    input  RGBOut, flashActive
  );

  modport slave (
    input  RGBIn, displayActive, startOfFrame, win, lose,
    output RGBOut, flashActive
  );
endinterface

// File: rtl/frame_flash_filter.sv
// End-of-game screen effect: flashes the picture inverted/normal for a fixed
// number of frame phases after a win or lose, then holds normal (win) or dim (lose).
module frame_flash_filter #(
  parameter int TOGGLE_FRAMES = 4,
  parameter int FLASH_TOGGLES = 6
) (
  input logic                 clk,
  input logic                 resetN,
  frame_flash_filter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLASH, END} state_t;
  typedef enum logic [1:0] {MODE_PASS, MODE_INVERT, MODE_DIM} mode_t;
  typedef enum logic {CAUSE_WIN, CAUSE_LOSE} cause_t;

  localparam logic [3:0] FRAME_LAST  = 4'(TOGGLE_FRAMES - 1);
  localparam logic [3:0] TOGGLE_LAST = 4'(FLASH_TOGGLES - 1);

  state_t     state, stateNext;
  cause_t     cause, causeNext;
  mode_t      mode;
  logic [3:0] frameCnt, frameCntNext;
  logic [3:0] toggleCnt, toggleCntNext;
  logic       invertPhase, invertPhaseNext;
  logic       winD, loseD;
  logic       winRise, loseRise;
  logic [7:0] pixelNext;

  assign winRise  = bus.win & ~winD;
  assign loseRise = bus.lose & ~loseD;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      cause       <= CAUSE_WIN;
      frameCnt    <= 4'd0;
      toggleCnt   <= 4'd0;
      invertPhase <= 1'b0;
      winD        <= 1'b0;
      loseD       <= 1'b0;
    end else begin
      state       <= stateNext;
      cause       <= causeNext;
      frameCnt    <= frameCntNext;
      toggleCnt   <= toggleCntNext;
      invertPhase <= invertPhaseNext;
      winD        <= bus.win;
      loseD       <= bus.lose;
    end
  end

  // Releasing both game levels always wins over a frame event in the same cycle.
  always_comb begin
    stateNext       = state;
    causeNext       = cause;
    frameCntNext    = frameCnt;
    toggleCntNext   = toggleCnt;
    invertPhaseNext = invertPhase;
    mode            = MODE_PASS;

    case (state)
      IDLE: begin
        if (winRise || loseRise) begin
          stateNext       = FLASH;
          causeNext       = winRise ? CAUSE_WIN : CAUSE_LOSE;
          frameCntNext    = 4'd0;
          toggleCntNext   = 4'd0;
          invertPhaseNext = 1'b1;
        end
      end

      FLASH: begin
        mode = invertPhase ? MODE_INVERT : MODE_PASS;
        if (!bus.win && !bus.lose) begin
          stateNext       = IDLE;
          frameCntNext    = 4'd0;
          toggleCntNext   = 4'd0;
          invertPhaseNext = 1'b0;
        end else if (bus.startOfFrame) begin
          if (frameCnt < FRAME_LAST) begin
            frameCntNext = frameCnt + 4'd1;
          end else begin
            frameCntNext    = 4'd0;
            invertPhaseNext = ~invertPhase;
            if (toggleCnt == TOGGLE_LAST) begin
              stateNext = END;
            end else begin
              toggleCntNext = toggleCnt + 4'd1;
            end
          end
        end
      end

      END: begin
        mode = (cause == CAUSE_WIN) ? MODE_PASS : MODE_DIM;
        if (!bus.win && !bus.lose) begin
          stateNext       = IDLE;
          frameCntNext    = 4'd0;
          toggleCntNext   = 4'd0;
          invertPhaseNext = 1'b0;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // DIM halves each RGB332 field independently so colours never bleed across fields.
  always_comb begin
    pixelNext = 8'h00;
    if (bus.displayActive) begin
      case (mode)
        MODE_INVERT: pixelNext = ~bus.RGBIn;
        MODE_DIM:    pixelNext = {1'b0, bus.RGBIn[7:6], 1'b0, bus.RGBIn[4:3], 1'b0, bus.RGBIn[1]};
        default:     pixelNext = bus.RGBIn;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      bus.RGBOut <= 8'h00;
    end else begin
      bus.RGBOut <= pixelNext;
    end
  end

  assign bus.flashActive = (state == FLASH);

endmodule

// File: doc/frame_flash_filter.md
FRAME_FLASH_FILTER -- requirements
Module: frame_flash_filter

Interface
REQ-001 Parameter TOGGLE_FRAMES, default 4: frames per flash phase; legal range 1..15.
REQ-002 Parameter FLASH_TOGGLES, default 6: number of phase toggles before the flash ends; legal range 1..15.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-004 clk  in  1  pixel clock; all state updates on the rising edge.
REQ-005 resetN  in  1  synchronous active-low reset.
REQ-006 RGBIn  in  8  RGB332 pixel from the object mux.
REQ-007 displayActive  in  1  high while the current pixel is in the visible area.
REQ-008 startOfFrame  in  1  single-cycle pulse, once per frame.
REQ-009 win  in  1  game-won level.
REQ-010 lose  in  1  game-lost level.
REQ-011 RGBOut  out  8  filtered RGB332 pixel to the VGA driver.
REQ-012 flashActive  out  1  high while the FSM is in FLASH.

Function
REQ-013 The datapath SHALL be registered with a latency of exactly 1 cycle: RGBOut(t+1) = f(RGBIn(t), displayActive(t), mode(t)).
REQ-014 If displayActive is 0, RGBOut SHALL be 8'h00, regardless of mode.
REQ-015 The transforms SHALL be defined as follows:
  - PASS: RGBOut = RGBIn.
  - INVERT: RGBOut = ~RGBIn.
  - DIM: each field shifted right by 1 — R[7:5]>>1, G[4:2]>>1, B[1:0]>>1.
REQ-016 Edge detection: winD and loseD SHALL be registered copies of win and lose.
  - winRise = win & ~winD; loseRise = lose & ~loseD.
REQ-017 The FSM SHALL have states IDLE, FLASH and END; its mode output is PASS in IDLE.
REQ-018 IDLE -> FLASH on winRise or loseRise.
  - On entry: cause is latched (win if winRise, else lose; winRise has priority when both rise in the same cycle).
  - On entry: frameCnt=0, toggleCnt=0, invertPhase=1.
REQ-019 In FLASH, mode SHALL be INVERT while invertPhase=1, otherwise PASS.
REQ-020 In FLASH, on each startOfFrame:
  - If frameCnt<TOGGLE_FRAMES-1, frameCnt increments.
  - Otherwise: frameCnt=0, invertPhase toggles, toggleCnt increments.
REQ-021 FLASH -> END on the startOfFrame that completes toggle number FLASH_TOGGLES (toggleCnt==FLASH_TOGGLES-1 at the wrap).
REQ-022 In END, mode SHALL be PASS if the latched cause is win and DIM if it is lose.
REQ-023 From FLASH or END, the FSM SHALL go to IDLE in the cycle after win=0 and lose=0; this takes priority over any counter event in the same cycle.
REQ-024 A new winRise or loseRise while in FLASH or END SHALL be ignored (no restart, cause unchanged).
REQ-025 The counters SHALL be 4 bits wide and never wrap beyond their parameter limits.
REQ-026 startOfFrame in the same cycle as FSM entry SHALL NOT count toward frameCnt.

Reset
REQ-027 When resetN=0 at a clock edge, the block SHALL be reset to: RGBOut=8'h00, flashActive=0, state=IDLE, winD=0, loseD=0, all counters=0, invertPhase=0, cause=win.
REQ-028 Reset mid-FLASH SHALL abort the flash; if win is still high when reset is released, winD=0 makes it a rising edge, so FLASH re-enters one cycle after release.

Verification
REQ-029 Passthrough: IDLE, displayActive=1, RGBIn=8'hA5 -> RGBOut=8'hA5 one cycle later; displayActive=0 -> 8'h00.
REQ-030 Win flash with defaults:
  - Stimulus: win rises, then RGBIn=8'hE0 held and 24 startOfFrame pulses applied.
  - Required: RGBOut=8'h1F during frames 0-3, 8-11 and 16-19; 8'hE0 during frames 4-7, 12-15 and 20-23.
  - Required: flashActive drops after the 24th pulse; END then outputs PASS.
REQ-031 Lose sequence: lose rises, 24 startOfFrame pulses, then RGBIn=8'hFF -> RGBOut=8'h6D (DIM) in END.
REQ-032 Simultaneous rise: win and lose rise in the same cycle -> cause=win, so END outputs PASS.
REQ-033 Abort: win and lose both drop at frame 10 of FLASH -> state=IDLE and flashActive=0 the next cycle, and RGBOut follows RGBIn.
REQ-034 Reset mid-flash: resetN=0 for 1 cycle at frame 5 with win held high -> RGBOut=8'h00 and flashActive=0 on that edge; FLASH restarts at frameCnt=0 one cycle after release.
